// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential multiplier:
//   - operand mode encodings (MUL_UU / MUL_SS / MUL_SU; 2'b11 behaves as UU)
//   - FSM state type (IDLE -> CALC -> FIX -> IDLE)
//   - cnt_w(): width of the iteration counter, large enough to hold WIDTH
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam logic [1:0] MUL_UU = 2'b00;  // unsigned x unsigned
    localparam logic [1:0] MUL_SS = 2'b01;  // signed x signed
    localparam logic [1:0] MUL_SU = 2'b10;  // signed multiplicand x unsigned multiplier

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // The counter is loaded with WIDTH itself, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_abs.sv
// ---------------------------------------------------------------------------
// mul_abs
// Conditional two's-complement negation: result = neg_en ? -value : value.
// Used both to take operand magnitudes (W = WIDTH) and to apply the final
// sign correction to the product (W = 2*WIDTH).
//
// Ports
//   value   in   W   operand
//   neg_en  in   1   negate when high
//   result  out  W   value or its two's complement
//
// The magnitude of the most negative W-bit value is 2^(W-1), which is still
// representable as a W-bit unsigned number, so no extra bit is needed.
// ---------------------------------------------------------------------------
module mul_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg_en,
    output logic [W-1:0] result
);

    assign result = neg_en ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle radix-2 shift-add integer multiplier. Operands are converted to
// magnitudes on acceptance, multiplied unsigned over WIDTH iterations, and the
// 2*WIDTH-bit result is negated in a final FIX cycle when exactly one operand
// was negative.
//
// Ports
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous active-low reset
//   start         in   1          request, accepted only in IDLE
//   mode          in   2          00 UU, 01 SS, 10 SU, 11 UU
//   multiplicand  in   WIDTH      operand A, captured on acceptance
//   multiplier    in   WIDTH      operand B, captured on acceptance
//   busy          out  1          high during CALC and FIX (WIDTH+1 cycles)
//   done          out  1          one-cycle pulse, product valid
//   product       out  2*WIDTH    result, held until the next FIX
//
// Timing: start sampled at edge N -> CALC for WIDTH cycles -> FIX for one
// cycle -> done high in the following cycle (state already back in IDLE, so a
// start presented alongside done is accepted immediately).
// ---------------------------------------------------------------------------
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     counter;

    // Datapath registers: magnitude of A, shifting magnitude of B, and the
    // running 2*WIDTH-bit accumulator.
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;

    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       partial;
    logic [2*WIDTH-1:0]   corrected;

    logic                 accept;
    logic                 last_step;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == CALC) && (counter == CNT_W'(1));
    assign busy      = (state != IDLE);

    // Operand signs depend on mode; an operand treated as unsigned never
    // counts as negative regardless of its top bit.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (mode)
            MUL_SS: begin
                sign_a = multiplicand[WIDTH-1];
                sign_b = multiplier[WIDTH-1];
            end
            MUL_SU: begin
                sign_a = multiplicand[WIDTH-1];
            end
            default: begin
                // MUL_UU and 2'b11: both operands unsigned
            end
        endcase
    end

    mul_abs #(.W(WIDTH)) u_abs_a (
        .value  (multiplicand),
        .neg_en (sign_a),
        .result (mag_a)
    );

    mul_abs #(.W(WIDTH)) u_abs_b (
        .value  (multiplier),
        .neg_en (sign_b),
        .result (mag_b)
    );

    // Add into the upper half with the carry kept as bit WIDTH; the carry
    // becomes the new MSB of the accumulator after the right shift, which is
    // what keeps the upper half exact for all-ones operands.
    assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    mul_abs #(.W(2*WIDTH)) u_abs_p (
        .value  (acc),
        .neg_en (neg),
        .result (corrected)
    );

    // -------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last_step) state_next = FIX;
            FIX:                    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Counter and shift-add datapath
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= mag_a;
                        mplr    <= mag_b;
                        acc     <= '0;
                        neg     <= sign_a ^ sign_b;
                        counter <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    // {carry, acc, mplr} >> 1: the bit leaving acc moves into
                    // the vacated top of mplr, whose consumed LSB drops out.
                    acc     <= {partial, acc[WIDTH-1:1]};
                    mplr    <= {acc[0], mplr[WIDTH-1:1]};
                    counter <= counter - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------
    // Result register and done pulse
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                product <= corrected;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier (WIDTH = 32). A table of directed
// vectors with known products is applied in a loop; further operations use a
// reference product computed with the native multiply operator. Expected
// products are queued when an operation is issued and compared when done
// pulses. Hand-written sequences cover start-while-busy, back-to-back start
// on the done cycle, and reset in the middle of a calculation.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int WIDTH   = 32;
    localparam int LAT     = WIDTH + 2;  // cycle index in which done is high
    localparam int BUSY_N  = WIDTH + 1;  // cycles busy is high per operation

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int total = 0;
    int bad   = 0;

    logic [2*WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [1:0]         mode;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    // Reference product from sign/zero-extended operands.
    function automatic logic [63:0] model(input logic [1:0] m, input logic [31:0] x,
                                         input logic [31:0] y);
        logic signed [64:0] ex;
        logic signed [64:0] ey;
        logic signed [64:0] p;
        case (m)
            2'b01: begin
                ex = {{33{x[31]}}, x};
                ey = {{33{y[31]}}, y};
            end
            2'b10: begin
                ex = {{33{x[31]}}, x};
                ey = {33'b0, y};
            end
            default: begin
                ex = {33'b0, x};
                ey = {33'b0, y};
            end
        endcase
        p = ex * ey;
        return p[63:0];
    endfunction

    // Called just after a falling edge; returns 1 ns after the accepting edge
    // with the operand inputs scrambled to show they are no longer sampled.
    task automatic issue(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        mode  = 2'($urandom);
    endtask

    // Watches the operation to completion (bounded). Cycle 1 is the cycle
    // right after the accepting edge. Optionally pulses start in cycle
    // glitch_cyc to confirm it is ignored while busy. Returns at the falling
    // edge of the done cycle.
    task automatic finish_op(input string tag, input int glitch_cyc);
        int          cyc;
        int          bcnt;
        int          ovl;
        logic        seen;
        logic [63:0] e;
        cyc  = 0;
        bcnt = 0;
        ovl  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (glitch_cyc != 0 && c == glitch_cyc) begin
                start = 1'b1;
                mode  = 2'b00;
                a     = 32'h0000_1234;
                b     = 32'h0000_5678;
            end else if (glitch_cyc != 0 && c == glitch_cyc + 1) begin
                start = 1'b0;
            end
            if (busy)         bcnt++;
            if (busy && done) ovl++;
            if (done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"},   64'(cyc),  64'(LAT));
        check({tag, "_busy_len"},  64'(bcnt), 64'(BUSY_N));
        check({tag, "_overlap"},   64'(ovl),  64'd0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard: got empty queue required pending result", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_product"}, product, e);
        end
    endtask

    // Counts done pulses and busy cycles over an idle window.
    task automatic quiet_window(input string tag, input int n);
        int dcnt;
        int bcnt;
        dcnt = 0;
        bcnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check({tag, "_no_done"}, 64'(dcnt), 64'd0);
        check({tag, "_no_busy"}, 64'(bcnt), 64'd0);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [1:0]  rm;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        a     = '0;
        b     = '0;

        vecs[0]  = '{2'b00, 32'd50,        32'd50,        64'h0000_0000_0000_09C4};
        vecs[1]  = '{2'b00, 32'd50,        32'd1000,      64'h0000_0000_0000_C350};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[4]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[5]  = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[6]  = '{2'b10, 32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE};
        vecs[7]  = '{2'b00, 32'd7,         32'd0,         64'h0000_0000_0000_0000};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'd3,         64'h0000_0002_FFFF_FFFD};
        vecs[9]  = '{2'b01, 32'd0,         32'h8000_0000, 64'h0000_0000_0000_0000};
        vecs[10] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_8000_0000};

        // Reset values
        #12;
        check("reset_busy",    64'(busy),    64'd0);
        check("reset_done",    64'(done),    64'd0);
        check("reset_product", product,      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);
            finish_op($sformatf("vec%0d", i), 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Random operands against the reference product
        for (int i = 0; i < 4; i++) begin
            rx = $urandom;
            ry = $urandom;
            rm = 2'(i);
            issue(rm, rx, ry, model(rm, rx, ry));
            finish_op($sformatf("rand%0d", i), 0);
            @(negedge clk);
        end

        // start pulsed while busy is ignored
        issue(2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        finish_op("busy_start", 5);
        quiet_window("busy_start_after", WIDTH + 8);

        // Back-to-back: second start presented in the done cycle
        @(negedge clk);
        issue(2'b00, 32'd50, 32'd50, 64'h0000_0000_0000_09C4);
        finish_op("b2b_first", 0);
        issue(2'b00, 32'd50, 32'd1000, 64'h0000_0000_0000_C350);
        check("b2b_accept_busy", 64'(busy), 64'd1);
        check("b2b_product_held", product, 64'h0000_0000_0000_09C4);
        finish_op("b2b_second", 0);
        @(negedge clk);

        // Reset in the middle of CALC
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    64'(busy), 64'd0);
        check("midrst_done",    64'(done), 64'd0);
        check("midrst_product", product,   64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("midrst_after", WIDTH + 8);
        issue(2'b10, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        finish_op("post_rst", 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
